// File: rtl/gf2m_trinomial_reducer_if.sv
// Valid/ready handshake bundle carrying an unreduced GF(2)[x] product in and
// the reduced GF(2^M) element out.
interface gf2m_trinomial_reducer_if #(
   parameter int M = 409
);
   logic             in_valid;
   logic             in_ready;
   logic [2*M-2:0]   in_prod;
   logic             out_valid;
   logic             out_ready;
   logic [M-1:0]     out_res;

   modport master (
      output in_valid, in_prod, out_ready,
      input  in_ready, out_valid, out_res
   );

   modport slave (
      input  in_valid, in_prod, out_ready,
      output in_ready, out_valid, out_res
   );
endinterface

// File: rtl/gf2m_trinomial_reducer.sv
// Two-fold sequential reduction of a (2M-1)-bit carry-less product modulo the
// trinomial x^M + x^K + 1, with valid/ready handshakes on both sides.
module gf2m_trinomial_reducer #(
   parameter int M = 409,
   parameter int K = 87
) (
   input  logic                    clk,
   input  logic                    rst_n,
   gf2m_trinomial_reducer_if.slave bus,
   output logic                    busy
);
   localparam int PW = 2*M-1;

   // K beyond (M+1)/2 would leave high terms after the second fold.
   generate
      if (K < 1 || K > (M+1)/2) begin : g_bad_k
         $error("gf2m_trinomial_reducer: K out of range 1..(M+1)/2");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FOLD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_cnt;
   logic [PW-1:0]   r_work;
   logic            r_out_valid;
   logic [M-1:0]    r_out_res;
   logic            w_in_ready;
   logic            w_load;
   logic [PW-1:0]   w_fold;

   // x^M == x^K + 1, so the high half H folds back in at offsets 0 and K.
   function automatic logic [PW-1:0] fold(input logic [PW-1:0] v);
      logic [PW-1:0] lo;
      logic [PW-1:0] hi;
      lo = {{(M-1){1'b0}}, v[M-1:0]};
      hi = {{M{1'b0}}, v[PW-1:M]};
      fold = lo ^ hi ^ (hi << K);
   endfunction

   assign w_fold = fold(r_work);

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_load      = 1'b1;
               w_state_nxt = S_FOLD;
            end
         end
         S_FOLD: begin
            if (r_cnt) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_in_ready = bus.out_ready;
            if (bus.out_ready) begin
               w_load      = bus.in_valid;
               w_state_nxt = bus.in_valid ? S_FOLD : S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 1'b0;
         r_work      <= '0;
         r_out_valid <= 1'b0;
         r_out_res   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_work <= bus.in_prod;
            r_cnt  <= 1'b0;
         end else if (r_state == S_FOLD) begin
            r_work <= w_fold;
            r_cnt  <= r_cnt + 1'b1;
         end
         // Result is captured into its own flops so out_res never sees r_work.
         if (r_state == S_FOLD && r_cnt) begin
            r_out_valid <= 1'b1;
            r_out_res   <= w_fold[M-1:0];
         end else if (r_state == S_DONE && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_res   = r_out_res;
   assign busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_gf2m_trinomial_reducer.sv
// Randomized self-checking bench for gf2m_trinomial_reducer at GF(2^409) and
// GF(2^7), against a bit-serial polynomial long-division reference.
module tb_gf2m_trinomial_reducer;
   localparam int MB = 409;
   localparam int KB = 87;
   localparam int MS = 7;
   localparam int KS = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy_b;
   logic busy_s;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   gf2m_trinomial_reducer_if #(.M(MB)) bb ();
   gf2m_trinomial_reducer_if #(.M(MS)) sb ();

   gf2m_trinomial_reducer #(.M(MB), .K(KB)) u_big (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bb.slave),
      .busy  (busy_b)
   );

   gf2m_trinomial_reducer #(.M(MS), .K(KS)) u_small (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sb.slave),
      .busy  (busy_s)
   );

   task automatic chk(input string tag, input logic [408:0] got, input logic [408:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Long division: cancel each high term with a shifted copy of the trinomial.
   function automatic logic [408:0] ref_mod(input logic [816:0] p, input int m, input int k);
      logic [816:0] v;
      v = p;
      for (int i = 2*m-2; i >= m; i--) begin
         if (v[i]) begin
            v[i]       = 1'b0;
            v[i-m+k]   = ~v[i-m+k];
            v[i-m]     = ~v[i-m];
         end
      end
      ref_mod = '0;
      for (int i = 0; i < m; i++) ref_mod[i] = v[i];
   endfunction

   function automatic logic [816:0] rand_big();
      logic [831:0] t;
      for (int i = 0; i < 26; i++) t[i*32 +: 32] = $urandom;
      return t[816:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_big(input logic [816:0] p, output logic [408:0] res, output int lat);
      bb.in_prod   = p;
      bb.in_valid  = 1'b1;
      bb.out_ready = 1'b1;
      tick();
      lat = 1;
      bb.in_valid = 1'b0;
      while (!bb.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      res = bb.out_res;
   endtask

   task automatic run_small(input logic [12:0] p, output logic [6:0] res, output int lat);
      sb.in_prod   = p;
      sb.in_valid  = 1'b1;
      sb.out_ready = 1'b1;
      tick();
      lat = 1;
      sb.in_valid = 1'b0;
      while (!sb.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      res = sb.out_res;
   endtask

   initial begin
      logic [816:0] p, p1, p2;
      logic [408:0] e, res;
      logic [6:0]   sres;
      logic [12:0]  sp;
      int           lat, n, seen, acc, got, last, cyc;
      logic         fire;
      logic [408:0] q[$];

      bb.in_valid = 1'b0; bb.in_prod = '0; bb.out_ready = 1'b0;
      sb.in_valid = 1'b0; sb.in_prod = '0; sb.out_ready = 1'b0;

      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_out_valid", bb.out_valid, 0);
      chk("rst_out_res", bb.out_res, 0);
      chk("rst_in_ready", bb.in_ready, 1);
      chk("rst_busy", busy_b, 0);
      chk("rst_s_out_valid", sb.out_valid, 0);
      chk("rst_s_busy", busy_s, 0);
      rst_n = 1'b1;
      tick();

      // Fixed vectors at GF(2^409)
      p = '0; p[408] = 1'b1; e = '0; e[408] = 1'b1;
      run_big(p, res, lat);
      chk("x408_res", res, e);
      chk("x408_lat", lat, 3);
      p = '0; p[409] = 1'b1; e = '0; e[87] = 1'b1; e[0] = 1'b1;
      run_big(p, res, lat);
      chk("x409_res", res, e);
      chk("x409_lat", lat, 3);
      p = '0; p[816] = 1'b1; e = '0; e[407] = 1'b1; e[172] = 1'b1; e[85] = 1'b1;
      run_big(p, res, lat);
      chk("x816_res", res, e);
      for (int i = 0; i < 4; i++) begin
         p = rand_big();
         run_big(p, res, lat);
         chk("big_rand_res", res, ref_mod(p, MB, KB));
         chk("big_rand_lat", lat, 3);
      end
      tick();

      // Small field
      sp = 13'h0; sp[12] = 1'b1;
      run_small(sp, sres, lat);
      chk("s_x12", sres, 7'b1100000);
      chk("s_x12_lat", lat, 3);
      for (int i = 0; i < 200; i++) begin
         sp = 13'($urandom);
         run_small(sp, sres, lat);
         chk("s_rand", sres, ref_mod({804'b0, sp}, MS, KS));
      end
      tick();

      // Backpressure: result holds, input blocked, in_prod changes ignored
      p1 = rand_big(); p2 = rand_big();
      bb.out_ready = 1'b0; bb.in_valid = 1'b1; bb.in_prod = p1;
      tick();
      bb.in_prod = p2;
      n = 0;
      while (!bb.out_valid && n < 20) begin
         tick();
         n++;
      end
      chk("bp_lat", n, 2);
      chk("bp_res", bb.out_res, ref_mod(p1, MB, KB));
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_res", bb.out_res, ref_mod(p1, MB, KB));
         chk("bp_hold_valid", bb.out_valid, 1);
         chk("bp_in_ready", bb.in_ready, 0);
      end
      bb.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", bb.in_ready, 1);
      tick();
      bb.in_valid = 1'b0;
      n = 1;
      while (!bb.out_valid && n < 20) begin
         tick();
         n++;
      end
      chk("bp_next_lat", n, 3);
      chk("bp_next_res", bb.out_res, ref_mod(p2, MB, KB));
      tick();

      // Reset while folding discards the product
      bb.in_valid = 1'b1; bb.in_prod = rand_big(); bb.out_ready = 1'b1;
      tick();
      bb.in_valid = 1'b0;
      chk("midrst_busy_fold", busy_b, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_out_valid", bb.out_valid, 0);
      chk("midrst_busy", busy_b, 0);
      chk("midrst_out_res", bb.out_res, 0);
      chk("midrst_in_ready", bb.in_ready, 1);
      seen = 0;
      repeat (5) begin
         tick();
         if (bb.out_valid) seen++;
      end
      chk("midrst_no_emit", seen, 0);
      run_big('0, res, lat);
      chk("midrst_zero_res", res, 0);
      chk("midrst_zero_lat", lat, 3);
      tick();

      // Back-to-back streaming
      acc = 0; got = 0; last = -1; cyc = 0;
      bb.out_ready = 1'b1; bb.in_valid = 1'b1; bb.in_prod = rand_big();
      while (got < 10 && cyc < 200) begin
         fire = bb.in_valid && bb.in_ready;
         if (fire) q.push_back(ref_mod(bb.in_prod, MB, KB));
         tick();
         cyc++;
         if (fire) begin
            acc++;
            if (acc < 10) bb.in_prod = rand_big();
            else bb.in_valid = 1'b0;
         end
         if (bb.out_valid) begin
            if (q.size() > 0) chk("b2b_res", bb.out_res, q.pop_front());
            else chk("b2b_unexpected", 1, 0);
            if (last >= 0) chk("b2b_gap", cyc - last, 3);
            last = cyc;
            got++;
         end
      end
      chk("b2b_count", got, 10);
      chk("b2b_accepted", acc, 10);
      tick();
      chk("b2b_idle", busy_b, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
